// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive path.
// Optional build macro used by the receiver: UART_RX_MAJORITY_EN.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      TAIL  = 2'b11
   } uart_state_e;

   localparam logic UART_IDLE_LEVEL = 1'b1;

   function automatic int tick_w(input int os);
      return (os < 2) ? 1 : $clog2(os);
   endfunction

   function automatic int bit_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte handoff bundle: byte, status flags and valid/ready.
// The receiver drives the master side; the consumer owns rx_ready.
interface uart_rx_ctrl_if #(
   parameter int DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  overrun_err,
      output rx_ready
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to the idle (high) line level.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic baud_clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= UART_IDLE_LEVEL;
         q    <= UART_IDLE_LEVEL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit sampling, byte handoff.
// Build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic          baud_clk,
   input  logic          rst_n,
   input  logic          data_tx,
   output logic [1:0]    current_state,
   output logic          shift,
   output logic          busy,
   uart_rx_ctrl_if.master rx
);

   localparam int TW = tick_w(OVERSAMPLE);
   localparam int BW = bit_w(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
   localparam int MID_OFS = 1;
`else
   localparam int MID_OFS = 0;
`endif

   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1 + MID_OFS);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          ODD       = 1'(PARITY_ODD);

   logic                 rxs;
   logic                 bit_s;
   uart_state_e          state;
   logic [TW-1:0]        tick;
   logic [BW-1:0]        bitc;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_seen;
   logic                 par_err_q;
   logic                 armed;
   logic                 at_last;

   uart_rx_sync u_sync (
      .baud_clk (baud_clk),
      .rst_n    (rst_n),
      .d        (data_tx),
      .q        (rxs)
   );

`ifdef UART_RX_MAJORITY_EN
   // Window holds rxs of the two previous cycles; decision lands one tick late.
   logic [1:0] hist;

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= {2{UART_IDLE_LEVEL}};
      end else begin
         hist <= {hist[0], rxs};
      end
   end

   assign bit_s = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
   assign bit_s = rxs;
`endif

   assign at_last       = (tick == TICK_LAST);
   assign shift         = (state == DATA) && at_last;
   assign current_state = state;
   assign busy          = (state != IDLE);

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         tick           <= '0;
         bitc           <= '0;
         shreg          <= '0;
         par_seen       <= 1'b0;
         par_err_q      <= 1'b0;
         armed          <= 1'b1;
         rx.rx_data     <= '0;
         rx.rx_valid    <= 1'b0;
         rx.parity_err  <= 1'b0;
         rx.frame_err   <= 1'b0;
         rx.overrun_err <= 1'b0;
      end else begin
         rx.overrun_err <= 1'b0;
         if (rx.rx_valid && rx.rx_ready) begin
            rx.rx_valid <= 1'b0;
         end
         if (rxs) begin
            armed <= 1'b1;
         end
         tick <= at_last ? '0 : tick + 1'b1;

         unique case (state)
            IDLE: begin
               if (armed && !rxs) begin
                  state <= START;
                  tick  <= '0;
               end
            end
            START: begin
               if (tick == TICK_MID) begin
                  if (!bit_s) begin
                     state <= DATA;
                     tick  <= '0;
                     bitc  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (at_last) begin
                  shreg <= {bit_s, shreg[DATA_BITS-1:1]};
                  bitc  <= bitc + 1'b1;
                  if (bitc == BIT_LAST) begin
                     state    <= TAIL;
                     tick     <= '0;
                     par_seen <= 1'b0;
                  end
               end
            end
            TAIL: begin
               if (at_last) begin
                  if (!par_seen) begin
                     par_seen  <= 1'b1;
                     par_err_q <= ^shreg ^ bit_s ^ ODD;
                  end else begin
                     // Back to IDLE half a bit early to resync on the next start.
                     state <= IDLE;
                     if (!bit_s) begin
                        armed <= 1'b0;
                     end
                     if (!rx.rx_valid || rx.rx_ready) begin
                        rx.rx_data    <= shreg;
                        rx.parity_err <= par_err_q;
                        rx.frame_err  <= !bit_s;
                        rx.rx_valid   <= 1'b1;
                     end else begin
                        rx.overrun_err <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at OVERSAMPLE=16, 8 data bits, even parity.
// Frames are bit-banged on data_tx; outputs are sampled on the falling edge.
module tb_uart_rx_ctrl;

   localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 172;
`else
   localparam int LAT = 171;
`endif

   logic       baud_clk = 1'b0;
   logic       rst_n    = 1'b0;
   logic       data_tx  = 1'b1;
   logic [1:0] current_state;
   logic       shift;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_shift = 0;
   int n_valid = 0;
   int n_ovr   = 0;
   int rise_cyc = 0;
   int fall_cyc = 0;
   logic rv_prev = 1'b0;

   uart_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_ctrl #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (8),
      .PARITY_ODD (0)
   ) dut (
      .baud_clk      (baud_clk),
      .rst_n         (rst_n),
      .data_tx       (data_tx),
      .current_state (current_state),
      .shift         (shift),
      .busy          (busy),
      .rx            (rx_if)
   );

   always #5 baud_clk = ~baud_clk;

   always @(posedge baud_clk) cyc <= cyc + 1;

   always @(negedge baud_clk) begin
      if (shift) n_shift = n_shift + 1;
      if (rx_if.overrun_err) n_ovr = n_ovr + 1;
      if (rx_if.rx_valid && !rv_prev) begin
         n_valid  = n_valid + 1;
         rise_cyc = cyc;
      end
      rv_prev = rx_if.rx_valid;
   end

   task automatic send_bit(input logic b);
      data_tx = b;
      repeat (OS) @(posedge baud_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par,
                             input logic stp);
      fall_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stp);
   endtask

   task automatic pop();
      @(posedge baud_clk); #1;
      rx_if.rx_ready = 1'b1;
      @(posedge baud_clk); #1;
      rx_if.rx_ready = 1'b0;
      @(negedge baud_clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      data_tx = 1'b1;
      rx_if.rx_ready = 1'b0;
      repeat (3) @(negedge baud_clk);
      total++;
      if (current_state !== 2'b00) begin
         bad++;
         $display("FAIL reset_state got=%b want=00", current_state);
      end
      total++;
      if ({shift, busy, rx_if.rx_valid} !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctl got=%b want=000",
                  {shift, busy, rx_if.rx_valid});
      end
      total++;
      if (rx_if.rx_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_data got=%h want=00", rx_if.rx_data);
      end
      total++;
      if ({rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err} !== 3'b000)
      begin
         bad++;
         $display("FAIL reset_err got=%b want=000",
                  {rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err});
      end
      @(posedge baud_clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge baud_clk);
      #1;
   endtask

   task automatic test_basic();
      int s0, v0;
      s0 = n_shift;
      v0 = n_valid;
      send_frame(8'hA5, 1'b0, 1'b1);
      data_tx = 1'b1;
      repeat (4) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (n_shift - s0 !== 8) begin
         bad++;
         $display("FAIL basic_shifts got=%0d want=8", n_shift - s0);
      end
      total++;
      if (n_valid - v0 !== 1 || rx_if.rx_valid !== 1'b1) begin
         bad++;
         $display("FAIL basic_valid got=%0d/%b want=1/1",
                  n_valid - v0, rx_if.rx_valid);
      end
      total++;
      if (rise_cyc - fall_cyc !== LAT) begin
         bad++;
         $display("FAIL basic_latency got=%0d want=%0d",
                  rise_cyc - fall_cyc, LAT);
      end
      total++;
      if (rx_if.rx_data !== 8'hA5) begin
         bad++;
         $display("FAIL basic_data got=%h want=a5", rx_if.rx_data);
      end
      total++;
      if ({rx_if.parity_err, rx_if.frame_err} !== 2'b00) begin
         bad++;
         $display("FAIL basic_err got=%b want=00",
                  {rx_if.parity_err, rx_if.frame_err});
      end
      total++;
      if (busy !== 1'b0 || current_state !== 2'b00) begin
         bad++;
         $display("FAIL basic_idle got=%b/%b want=0/00", busy, current_state);
      end
      pop();
      total++;
      if (rx_if.rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_pop got=%b want=0", rx_if.rx_valid);
      end
   endtask

   task automatic test_parity();
      send_frame(8'h01, 1'b0, 1'b1);
      data_tx = 1'b1;
      repeat (4) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (rx_if.rx_data !== 8'h01 || rx_if.rx_valid !== 1'b1) begin
         bad++;
         $display("FAIL par_data got=%h/%b want=01/1",
                  rx_if.rx_data, rx_if.rx_valid);
      end
      total++;
      if ({rx_if.parity_err, rx_if.frame_err} !== 2'b10) begin
         bad++;
         $display("FAIL par_flags got=%b want=10",
                  {rx_if.parity_err, rx_if.frame_err});
      end
      pop();
   endtask

   task automatic test_break();
      int v0, o0;
      v0 = n_valid;
      o0 = n_ovr;
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (40 * OS) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL brk_busy got=%b want=0", busy);
      end
      #1 data_tx = 1'b1;
      repeat (2 * OS) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (n_valid - v0 !== 1 || n_ovr - o0 !== 0) begin
         bad++;
         $display("FAIL brk_frames got=%0d/%0d want=1/0",
                  n_valid - v0, n_ovr - o0);
      end
      total++;
      if (rx_if.rx_data !== 8'h3C) begin
         bad++;
         $display("FAIL brk_data got=%h want=3c", rx_if.rx_data);
      end
      total++;
      if ({rx_if.parity_err, rx_if.frame_err} !== 2'b01) begin
         bad++;
         $display("FAIL brk_flags got=%b want=01",
                  {rx_if.parity_err, rx_if.frame_err});
      end
      pop();
   endtask

   task automatic test_glitch();
      int s0, v0;
      s0 = n_shift;
      v0 = n_valid;
      @(posedge baud_clk); #1;
      data_tx = 1'b0;
      repeat (4) @(posedge baud_clk);
      #1 data_tx = 1'b1;
      @(negedge baud_clk);
      total++;
      if (current_state !== 2'b01 || busy !== 1'b1) begin
         bad++;
         $display("FAIL glitch_start got=%b/%b want=01/1",
                  current_state, busy);
      end
      repeat (20) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (current_state !== 2'b00) begin
         bad++;
         $display("FAIL glitch_idle got=%b want=00", current_state);
      end
      total++;
      if (n_shift - s0 !== 0 || n_valid - v0 !== 0) begin
         bad++;
         $display("FAIL glitch_out got=%0d/%0d want=0/0",
                  n_shift - s0, n_valid - v0);
      end
   endtask

   task automatic test_back_to_back();
      int o0;
      o0 = n_ovr;
      send_frame(8'h11, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1);
      data_tx = 1'b1;
      repeat (4) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (rx_if.rx_data !== 8'h11 || rx_if.rx_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_hold got=%h/%b want=11/1",
                  rx_if.rx_data, rx_if.rx_valid);
      end
      total++;
      if (n_ovr - o0 !== 1) begin
         bad++;
         $display("FAIL b2b_overrun got=%0d want=1", n_ovr - o0);
      end
      total++;
      if ({rx_if.parity_err, rx_if.frame_err} !== 2'b00) begin
         bad++;
         $display("FAIL b2b_flags got=%b want=00",
                  {rx_if.parity_err, rx_if.frame_err});
      end
      pop();
      total++;
      if (rx_if.rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_pop got=%b want=0", rx_if.rx_valid);
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      repeat (8) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (current_state !== 2'b10) begin
         bad++;
         $display("FAIL rmid_pre got=%b want=10", current_state);
      end
      @(posedge baud_clk); #1;
      rst_n = 1'b0;
      #2;
      total++;
      if ({current_state, busy, shift, rx_if.rx_valid} !== 5'b00000) begin
         bad++;
         $display("FAIL rmid_async got=%b want=00000",
                  {current_state, busy, shift, rx_if.rx_valid});
      end
      data_tx = 1'b1;
      repeat (3) @(posedge baud_clk);
      #1 rst_n = 1'b1;
      repeat (2 * OS) @(posedge baud_clk);
      #1;
      s0 = n_shift;
      send_frame(8'h5A, 1'b0, 1'b1);
      data_tx = 1'b1;
      repeat (4) @(posedge baud_clk);
      @(negedge baud_clk);
      total++;
      if (rx_if.rx_data !== 8'h5A || rx_if.rx_valid !== 1'b1) begin
         bad++;
         $display("FAIL rmid_data got=%h/%b want=5a/1",
                  rx_if.rx_data, rx_if.rx_valid);
      end
      total++;
      if (n_shift - s0 !== 8 ||
          {rx_if.parity_err, rx_if.frame_err} !== 2'b00) begin
         bad++;
         $display("FAIL rmid_flags got=%0d/%b want=8/00", n_shift - s0,
                  {rx_if.parity_err, rx_if.frame_err});
      end
      pop();
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_break();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
